axi_cache_bridge: RTL

Single-outstanding AXI4 master that turns cache refill/writeback requests into INCR bursts toward the simulation SRAM slave (`sim_sram_dpic`) or any AXI4 slave. It sits directly upstream of that slave, between the L1 cache miss/writeback logic and the AXI bus. It supports exclusive accesses for LR/SC and returns read beats and write responses on one response stream. It also flags burst-length mismatches.

---
 rtl/axi_cache_bridge_pkg.sv | 25 ++
 rtl/axi_cache_bridge_if.sv | 94 +++++++++
 rtl/axi_cache_bridge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_cache_bridge_pkg.sv
// -----------------------------------------------------------------------------
// axi_bridge_pkg
// Shared types and constants for the cache-to-AXI4 bridge: the bridge FSM
// state encoding, the INCR burst code and the AXI response codes.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_cache_bridge_if.sv
// -----------------------------------------------------------------------------
// axi_cache_bridge_if
// AXI4 bus bundle between the cache bridge (master) and an AXI4 slave.
// Channels: AW, W, B, AR, R with full AXI4 address-side sideband fields.
// Modports:
//   master - drives AW/W/AR payloads and valids, bready, rready
//   slave  - drives awready, wready, B channel, arready, R channel
// -----------------------------------------------------------------------------
interface axi_cache_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int ID_W   = 8,
    parameter int DATA_W = 64
);

    // AW channel
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [3:0]        awregion;
    logic [ID_W-1:0]   awid;

    // W channel
    logic                wvalid;
    logic                wready;
    logic                wlast;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;

    // B channel
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    // AR channel
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [3:0]        arregion;
    logic [ID_W-1:0]   arid;

    // R channel
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awregion, awid,
        input  awready,
        output wvalid, wlast, wdata, wstrb,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arqos, arregion, arid,
        input  arready,
        input  rvalid, rid, rresp, rdata, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awregion, awid,
        output awready,
        input  wvalid, wlast, wdata, wstrb,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache,
               arprot, arqos, arregion, arid,
        output arready,
        output rvalid, rid, rresp, rdata, rlast,
        input  rready
    );

endinterface

// File: rtl/axi_cache_bridge.sv
// -----------------------------------------------------------------------------
// axi_cache_bridge
// Single-outstanding AXI4 master turning cache refill (read) and writeback
// (write) requests into INCR bursts. Read beats and write responses come
// back on one response stream; exclusive (LR/SC) accesses are supported
// through req_lock and the forwarded EXOKAY/error responses.
//
// Ports:
//   aclk, arst            clock, asynchronous active-high reset
//   req_*                 request handshake: write/addr/len/size/lock
//   wd_*                  write-beat stream (data, strobes)
//   rsp_*                 response stream (read beats, or one write response)
//   proto_err             sticky flag: rlast disagreed with the beat count
//   m_axi                 AXI4 master bus (axi_cache_bridge_if.master)
// -----------------------------------------------------------------------------
module axi_cache_bridge
    import axi_bridge_pkg::*;
#(
    parameter int AXI_ADDR_W = 64,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 64,
    parameter int MST_ID     = 0
) (
    input  logic                    aclk,
    input  logic                    arst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AXI_ADDR_W-1:0]   req_addr,
    input  logic [7:0]              req_len,
    input  logic [2:0]              req_size,
    input  logic                    req_lock,

    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [AXI_DATA_W-1:0]   wd_data,
    input  logic [AXI_DATA_W/8-1:0] wd_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [AXI_DATA_W-1:0]   rsp_data,
    output logic                    rsp_last,
    output logic [1:0]              rsp_resp,

    output logic                    proto_err,

    axi_cache_bridge_if.master      m_axi
);

    state_e                  state_q;
    state_e                  state_d;
    logic [AXI_ADDR_W-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic                    lock_q;
    logic [7:0]              beat_cnt;
    logic                    proto_err_q;

    logic                    r_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    cnt_zero;

    // IDs are constant for a single-outstanding master, so returned IDs
    // carry no information and are intentionally ignored.
    logic                    unused_ids;
    assign unused_ids = ^{m_axi.rid, m_axi.bid};

    assign cnt_zero = (beat_cnt == 8'd0);
    assign r_hs     = (state_q == ST_R) && m_axi.rvalid && rsp_ready;
    assign w_hs     = (state_q == ST_W) && wd_valid && m_axi.wready;
    assign b_hs     = (state_q == ST_B) && m_axi.bvalid && rsp_ready;

    // Address-channel payload always comes from the captured registers so it
    // stays stable while valid waits for ready.
    assign m_axi.awaddr   = addr_q;
    assign m_axi.awlen    = len_q;
    assign m_axi.awsize   = size_q;
    assign m_axi.awburst  = AXI_BURST_INCR;
    assign m_axi.awlock   = lock_q;
    assign m_axi.awcache  = 4'd0;
    assign m_axi.awprot   = 3'd0;
    assign m_axi.awqos    = 4'd0;
    assign m_axi.awregion = 4'd0;
    assign m_axi.awid     = AXI_ID_W'(MST_ID);

    assign m_axi.araddr   = addr_q;
    assign m_axi.arlen    = len_q;
    assign m_axi.arsize   = size_q;
    assign m_axi.arburst  = AXI_BURST_INCR;
    assign m_axi.arlock   = lock_q;
    assign m_axi.arcache  = 4'd0;
    assign m_axi.arprot   = 3'd0;
    assign m_axi.arqos    = 4'd0;
    assign m_axi.arregion = 4'd0;
    assign m_axi.arid     = AXI_ID_W'(MST_ID);

    assign m_axi.wdata    = wd_data;
    assign m_axi.wstrb    = wd_strb;

    assign proto_err      = proto_err_q;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus all handshake outputs. Valids depend only on the state
    // register (and on the pass-through source valids), never on a ready.
    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        wd_ready         = 1'b0;
        rsp_valid        = 1'b0;
        rsp_data         = '0;
        rsp_last         = 1'b0;
        rsp_resp         = AXI_RESP_OKAY;
        m_axi.arvalid    = 1'b0;
        m_axi.awvalid    = 1'b0;
        m_axi.wvalid     = 1'b0;
        m_axi.wlast      = 1'b0;
        m_axi.bready     = 1'b0;
        m_axi.rready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_write ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rsp_valid    = m_axi.rvalid;
                m_axi.rready = rsp_ready;
                rsp_data     = m_axi.rdata;
                rsp_resp     = m_axi.rresp;
                rsp_last     = m_axi.rlast;
                // The slave's rlast ends the burst even if the count disagrees.
                if (r_hs && m_axi.rlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_AW: begin
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                m_axi.wvalid = wd_valid;
                wd_ready     = m_axi.wready;
                m_axi.wlast  = cnt_zero;
                if (w_hs && cnt_zero) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                rsp_valid    = m_axi.bvalid;
                m_axi.bready = rsp_ready;
                rsp_last     = 1'b1;
                rsp_resp     = m_axi.bresp;
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, remaining-beat counter and sticky protocol flag.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            addr_q      <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            lock_q      <= 1'b0;
            beat_cnt    <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && req_valid) begin
                addr_q   <= req_addr;
                len_q    <= req_len;
                size_q   <= req_size;
                lock_q   <= req_lock;
                beat_cnt <= req_len;
            end else if (r_hs || w_hs) begin
                beat_cnt <= beat_cnt - 8'd1;
            end

            if (r_hs && (m_axi.rlast != cnt_zero)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule
